// File: rtl/xoro_pkg.sv
// rtl/xoro_pkg.sv - shared widths, defaults, FSM encoding and step function for xoro_gen
package xoro_pkg;

  localparam int STATE_W = 64;
  localparam int OUT_W   = 63;
  localparam int CNT_W   = 32;

  localparam logic [STATE_W-1:0] SEED0_DEF = 64'h0123_4567_89AB_CDEF;
  localparam logic [STATE_W-1:0] SEED1_DEF = 64'hFEDC_BA98_7654_3210;

  localparam int ROT_A_DEF = 24;
  localparam int SHL_B_DEF = 16;
  localparam int ROT_C_DEF = 37;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } xoro_state_e;

  function automatic logic [STATE_W-1:0] rotl(input logic [STATE_W-1:0] x, input int k);
    return (x << k) | (x >> (STATE_W - k));
  endfunction

  // Returns {s1', s0'} for one xoroshiro128 state advance.
  function automatic logic [2*STATE_W-1:0] xoro_step(
    input logic [STATE_W-1:0] s0,
    input logic [STATE_W-1:0] s1,
    input int                 rot_a = ROT_A_DEF,
    input int                 shl_b = SHL_B_DEF,
    input int                 rot_c = ROT_C_DEF
  );
    logic [STATE_W-1:0] t;
    t = s1 ^ s0;
    return {rotl(t, rot_c), rotl(s0, rot_a) ^ t ^ (t << shl_b)};
  endfunction

endpackage

// File: rtl/xoro_core.sv
// rtl/xoro_core.sv - combinational xoroshiro128+ state step and 63-bit sum output
module xoro_core
  import xoro_pkg::*;
#(
  parameter int ROT_A = ROT_A_DEF,
  parameter int SHL_B = SHL_B_DEF,
  parameter int ROT_C = ROT_C_DEF
) (
  input  logic [STATE_W-1:0] s0_i,
  input  logic [STATE_W-1:0] s1_i,
  output logic [STATE_W-1:0] s0_next_o,
  output logic [STATE_W-1:0] s1_next_o,
  output logic [OUT_W-1:0]   sum_x_o
);

  assign {s1_next_o, s0_next_o} = xoro_step(s0_i, s1_i, ROT_A, SHL_B, ROT_C);

  // The weak low bit of the sum is discarded; carry out of bit 63 is dropped.
  assign sum_x_o = OUT_W'((s0_i + s1_i) >> 1);

endmodule

// File: rtl/xoro_gen.sv
// rtl/xoro_gen.sv - xoroshiro128+ word source with valid/ready output and reseed port (optional XORO_ZERO_GUARD_EN)
module xoro_gen
  import xoro_pkg::*;
#(
  parameter logic [STATE_W-1:0] SEED0 = SEED0_DEF,
  parameter logic [STATE_W-1:0] SEED1 = SEED1_DEF,
  parameter int                 ROT_A = ROT_A_DEF,
  parameter int                 SHL_B = SHL_B_DEF,
  parameter int                 ROT_C = ROT_C_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic [2*STATE_W-1:0] seed_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_x,
  output logic [CNT_W-1:0]     out_count
`ifdef XORO_ZERO_GUARD_EN
  ,
  output logic                 zero_seen
`endif
);

  xoro_state_e        state_q, state_d;
  logic [STATE_W-1:0] s0_q, s0_d;
  logic [STATE_W-1:0] s1_q, s1_d;
  logic [OUT_W-1:0]   out_x_q, out_x_d;
  logic               out_valid_q, out_valid_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [STATE_W-1:0] s0_next, s1_next;
  logic [OUT_W-1:0]   sum_x;
  logic [STATE_W-1:0] load_s0, load_s1;
  logic               seed_load;

  xoro_core #(
    .ROT_A (ROT_A),
    .SHL_B (SHL_B),
    .ROT_C (ROT_C)
  ) u_core (
    .s0_i      (s0_q),
    .s1_i      (s1_q),
    .s0_next_o (s0_next),
    .s1_next_o (s1_next),
    .sum_x_o   (sum_x)
  );

  assign seed_ready = (state_q == RUN);
  assign seed_load  = seed_valid && seed_ready;

`ifdef XORO_ZERO_GUARD_EN
  logic zero_seen_q, zero_seen_d;
  logic seed_zero;

  // An all-zero state is a fixed point of the generator, so swap in the reset seeds.
  assign seed_zero = (seed_data == '0);
  assign load_s0   = seed_zero ? SEED0 : seed_data[STATE_W-1:0];
  assign load_s1   = seed_zero ? SEED1 : seed_data[2*STATE_W-1:STATE_W];
  assign zero_seen = zero_seen_q;
  assign zero_seen_d = zero_seen_q | (seed_load & seed_zero);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      zero_seen_q <= 1'b0;
    end else begin
      zero_seen_q <= zero_seen_d;
    end
  end
`else
  assign load_s0 = seed_data[STATE_W-1:0];
  assign load_s1 = seed_data[2*STATE_W-1:STATE_W];
`endif

  always_comb begin
    state_d     = state_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    out_x_d     = out_x_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;

    unique case (state_q)
      FILL: begin
        out_x_d     = sum_x;
        s0_d        = s0_next;
        s1_d        = s1_next;
        out_valid_d = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (out_valid_q && out_ready) begin
          out_x_d = sum_x;
          s0_d    = s0_next;
          s1_d    = s1_next;
          count_d = count_q + 1'b1;
        end
        // A seed load overrides state and count even when a word transfers this cycle.
        if (seed_load) begin
          s0_d        = load_s0;
          s1_d        = load_s1;
          out_valid_d = 1'b0;
          count_d     = '0;
          state_d     = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FILL;
      s0_q        <= SEED0;
      s1_q        <= SEED1;
      out_x_q     <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      out_x_q     <= out_x_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign out_x     = out_x_q;
  assign out_valid = out_valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_xoro_gen.sv
// tb/tb_xoro_gen.sv - directed scoreboard bench for xoro_gen
module tb_xoro_gen;

  localparam logic [63:0] TB_SEED0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] TB_SEED1 = 64'hFEDC_BA98_7654_3210;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         seed_valid = 1'b0;
  logic         seed_ready;
  logic [127:0] seed_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [62:0]  out_x;
  logic [31:0]  out_count;
`ifdef XORO_ZERO_GUARD_EN
  logic         zero_seen;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [62:0] exp_q[$];
  logic [63:0] m0, m1;

  always #5 clk = ~clk;

  xoro_gen dut (
    .clk        (clk),
    .resetn     (resetn),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_data  (seed_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_count  (out_count)
`ifdef XORO_ZERO_GUARD_EN
    ,
    .zero_seen  (zero_seen)
`endif
  );

  function automatic logic [63:0] rotl64(input logic [63:0] x, input int k);
    logic [127:0] w;
    w = {x, x} << k;
    return w[127:64];
  endfunction

  task automatic model_step();
    logic [63:0] t;
    t  = m0 ^ m1;
    m0 = rotl64(m0, 24) ^ t ^ (t << 16);
    m1 = rotl64(t, 37);
  endtask

  task automatic model_seed(input logic [63:0] s1, input logic [63:0] s0);
    m0 = s0;
    m1 = s1;
    exp_q.delete();
  endtask

  task automatic model_push(input int n);
    logic [63:0] sum;
    for (int i = 0; i < n; i++) begin
      sum = m0 + m1;
      exp_q.push_back(sum[63:1]);
      model_step();
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) cyc();
    if (!out_valid) check({tag, "_timeout"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic take_word(input string tag);
    logic [62:0] e;
    out_ready = 1'b1;
    wait_valid(tag);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, {1'b0, out_x}, {1'b0, e});
    end
    cyc();
  endtask

  initial begin
    logic [62:0] e;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_x", {1'b0, out_x}, 64'd0);
    check("rst_count", {32'd0, out_count}, 64'd0);
    check("rst_seed_ready", {63'd0, seed_ready}, 64'd0);
`ifdef XORO_ZERO_GUARD_EN
    check("rst_zero_seen", {63'd0, zero_seen}, 64'd0);
`endif

    resetn = 1'b1;
    wait_valid("reset_first");
    check("reset_first_word", {1'b0, out_x}, {1'b0, 63'h7FFF_FFFF_FFFF_FFFF});
    check("run_seed_ready", {63'd0, seed_ready}, 64'd1);

    // Seed during stall: out_valid drops for exactly one cycle
    seed_data  = {64'd2, 64'd1};
    seed_valid = 1'b1;
    cyc();
    seed_valid = 1'b0;
    check("stall_seed_valid_drop", {63'd0, out_valid}, 64'd0);
    check("stall_seed_count", {32'd0, out_count}, 64'd0);
    cyc();
    check("stall_seed_valid_back", {63'd0, out_valid}, 64'd1);
    model_seed(64'd2, 64'd1);
    model_push(8);
    check("seed21_first_const", {1'b0, out_x}, 64'd1);
    take_word("seed21_w1");
    check("seed21_second_const", {1'b0, out_x}, {1'b0, 63'h30_0081_8001});
    take_word("seed21_w2");
    out_ready = 1'b0;
    check("seed21_count2", {32'd0, out_count}, 64'd2);

    // Backpressure: everything holds for 5 cycles, then no skip
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_x", {1'b0, out_x}, {1'b0, exp_q[0]});
      check("bp_count", {32'd0, out_count}, 64'd2);
      cyc();
    end
    take_word("bp_rel_w1");
    take_word("bp_rel_w2");
    take_word("bp_rel_w3");
    out_ready = 1'b0;
    check("bp_count5", {32'd0, out_count}, 64'd5);

    // Simultaneous output handshake and seed load
    out_ready  = 1'b1;
    seed_valid = 1'b1;
    seed_data  = {64'd2, 64'd1};
    e = exp_q.pop_front();
    check("simul_old_word", {1'b0, out_x}, {1'b0, e});
    cyc();
    seed_valid = 1'b0;
    out_ready  = 1'b0;
    model_seed(64'd2, 64'd1);
    model_push(6);
    check("simul_valid_drop", {63'd0, out_valid}, 64'd0);
    check("simul_count0", {32'd0, out_count}, 64'd0);
    wait_valid("simul_first");
    check("simul_first_const", {1'b0, out_x}, 64'd1);
    take_word("simul_first");
    out_ready = 1'b0;
    check("simul_count1", {32'd0, out_count}, 64'd1);

    // Async reset pulsed between clock edges
    take_word("pre_rst_w1");
    take_word("pre_rst_w2");
    #2 resetn = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_count", {32'd0, out_count}, 64'd0);
    check("arst_x", {1'b0, out_x}, 64'd0);
    @(negedge clk);
    out_ready = 1'b0;
    resetn    = 1'b1;
    model_seed(TB_SEED1, TB_SEED0);
    model_push(6);
    wait_valid("arst_first");
    check("arst_first_const", {1'b0, out_x}, {1'b0, 63'h7FFF_FFFF_FFFF_FFFF});
    take_word("arst_w1");
    take_word("arst_w2");
    out_ready = 1'b0;

    // All-zero seed
    seed_data  = '0;
    seed_valid = 1'b1;
    cyc();
    seed_valid = 1'b0;
`ifdef XORO_ZERO_GUARD_EN
    model_seed(TB_SEED1, TB_SEED0);
`else
    model_seed(64'd0, 64'd0);
`endif
    model_push(4);
    take_word("zero_w1");
    take_word("zero_w2");
    take_word("zero_w3");
    out_ready = 1'b0;
    check("zero_count3", {32'd0, out_count}, 64'd3);
`ifdef XORO_ZERO_GUARD_EN
    check("zero_seen_set", {63'd0, zero_seen}, 64'd1);
`else
    check("zero_x_stuck", {1'b0, out_x}, 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
